// File: rtl/osyrys_pkg.sv
// rtl/osyrys_pkg.sv - shared types and constants for the pipeline stall/flush controller
package osyrys_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MDU_WAIT = 2'd2,
        MEM_WAIT = 2'd3
    } ctrl_state_e;

    // Enables and flushes of the four pipeline registers, oldest stage last
    typedef struct packed {
        logic en_if_id;
        logic en_id_ex;
        logic en_ex_mem;
        logic en_mem_wb;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_ex_mem;
        logic flush_mem_wb;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_BOOT   = pipe_ctrl_t'(8'b0000_1111);
    localparam pipe_ctrl_t CTRL_NORMAL = pipe_ctrl_t'(8'b1111_0000);
    localparam pipe_ctrl_t CTRL_MEMW   = pipe_ctrl_t'(8'b0000_0001);
    // EX/MEM is flushed while the MDU op sits in EX, so its enable is irrelevant
    localparam pipe_ctrl_t CTRL_MDUW   = pipe_ctrl_t'(8'b0011_0010);
    localparam pipe_ctrl_t CTRL_REDIR  = pipe_ctrl_t'(8'b1111_1100);
    // ID/EX is flushed to form the bubble, so its enable is irrelevant
    localparam pipe_ctrl_t CTRL_LDUSE  = pipe_ctrl_t'(8'b0111_0100);

endpackage

// File: rtl/stall_perf_counters.sv
// rtl/stall_perf_counters.sv - saturating stall event counters (built only with OSYRYS_STALL_PERF_EN)
`ifdef OSYRYS_STALL_PERF_EN
module stall_perf_counters #(
    parameter int PERF_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_loaduse,
    input  logic              inc_memwait,
    input  logic              inc_flush,
    output logic [PERF_W-1:0] loaduse_cnt,
    output logic [PERF_W-1:0] memwait_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    // Count events, holding at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loaduse_cnt <= '0;
            memwait_cnt <= '0;
            flush_cnt   <= '0;
        end else begin
            if (inc_loaduse && (loaduse_cnt != '1)) loaduse_cnt <= loaduse_cnt + PERF_W'(1);
            if (inc_memwait && (memwait_cnt != '1)) memwait_cnt <= memwait_cnt + PERF_W'(1);
            if (inc_flush   && (flush_cnt   != '1)) flush_cnt   <= flush_cnt   + PERF_W'(1);
        end
    end

endmodule
`endif

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush controller for the five-stage core (optional perf counters: OSYRYS_STALL_PERF_EN)
module pipeline_ctrl
    import osyrys_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int PERF_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_redirect,
    input  logic              ex_mdu_start,
    input  logic              mdu_done,
    input  logic              mem_req_valid,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              en_if_id,
    output logic              en_id_ex,
    output logic              en_ex_mem,
    output logic              en_mem_wb,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              flush_ex_mem,
    output logic              flush_mem_wb
`ifdef OSYRYS_STALL_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_loaduse_cnt,
    output logic [PERF_W-1:0] perf_memwait_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

    ctrl_state_e state, state_nx;
    ctrl_state_e ret_state, ret_nx;
    logic        done_pending, pend_nx;
    pipe_ctrl_t  ctrl;
    logic        pc_en_c;
    logic        mem_wait, load_use, mdu_busy, done_eff;
    logic        ev_loaduse, ev_memwait, ev_flush;
    ctrl_state_e eff_state;

    // Hazard resolution: outputs and next state from current state and inputs
    always_comb begin
        mem_wait  = mem_req_valid & ~mem_ready;
        load_use  = ex_valid & ex_mem_read & (ex_rd != '0) &
                    ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
        mdu_busy  = ((state == MDU_WAIT) | ((state == RUN) & ex_mdu_start)) & ~mdu_done;
        // Leaving MEM_WAIT behaves like the state it interrupted, with any held completion
        eff_state = (state == MEM_WAIT) ? ret_state : state;
        done_eff  = mdu_done | ((state == MEM_WAIT) & done_pending);

        ctrl       = CTRL_NORMAL;
        pc_en_c    = 1'b1;
        state_nx   = state;
        ret_nx     = ret_state;
        pend_nx    = done_pending;
        ev_loaduse = 1'b0;
        ev_memwait = 1'b0;
        ev_flush   = 1'b0;

        if (state == BOOT) begin
            ctrl     = CTRL_BOOT;
            pc_en_c  = 1'b0;
            state_nx = RUN;
            pend_nx  = 1'b0;
        end else if (mem_wait) begin
            ctrl       = CTRL_MEMW;
            pc_en_c    = 1'b0;
            ev_memwait = 1'b1;
            if (state != MEM_WAIT) begin
                state_nx = MEM_WAIT;
                ret_nx   = mdu_busy ? MDU_WAIT : RUN;
                pend_nx  = 1'b0;
            end else begin
                pend_nx = done_pending | mdu_done;
            end
        end else begin
            pend_nx = 1'b0;
            if (eff_state == MDU_WAIT) begin
                if (done_eff) begin
                    state_nx = RUN;
                end else begin
                    ctrl     = CTRL_MDUW;
                    pc_en_c  = 1'b0;
                    state_nx = MDU_WAIT;
                end
            end else begin
                state_nx = RUN;
                if (ex_mdu_start & ~mdu_done) begin
                    ctrl     = CTRL_MDUW;
                    pc_en_c  = 1'b0;
                    state_nx = MDU_WAIT;
                end else if (ex_redirect & ex_valid) begin
                    ctrl     = CTRL_REDIR;
                    ev_flush = 1'b1;
                end else if (load_use) begin
                    ctrl       = CTRL_LDUSE;
                    pc_en_c    = 1'b0;
                    ev_loaduse = 1'b1;
                end
            end
        end
    end

    // Controller state, return state and held MDU completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BOOT;
            ret_state    <= RUN;
            done_pending <= 1'b0;
        end else begin
            state        <= state_nx;
            ret_state    <= ret_nx;
            done_pending <= pend_nx;
        end
    end

    assign pc_en        = pc_en_c;
    assign en_if_id     = ctrl.en_if_id;
    assign en_id_ex     = ctrl.en_id_ex;
    assign en_ex_mem    = ctrl.en_ex_mem;
    assign en_mem_wb    = ctrl.en_mem_wb;
    assign flush_if_id  = ctrl.flush_if_id;
    assign flush_id_ex  = ctrl.flush_id_ex;
    assign flush_ex_mem = ctrl.flush_ex_mem;
    assign flush_mem_wb = ctrl.flush_mem_wb;

`ifdef OSYRYS_STALL_PERF_EN
    stall_perf_counters #(
        .PERF_W(PERF_W)
    ) u_perf (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_loaduse(ev_loaduse),
        .inc_memwait(ev_memwait),
        .inc_flush  (ev_flush),
        .loaduse_cnt(perf_loaduse_cnt),
        .memwait_cnt(perf_memwait_cnt),
        .flush_cnt  (perf_flush_cnt)
    );
`else
    logic unused_perf;
    assign unused_perf = ev_loaduse ^ ev_memwait ^ ev_flush ^ (PERF_W == 0);
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

    localparam int REG_AW = 5;
    localparam int PERF_W = 64;

    // {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, fl_if_id, fl_id_ex, fl_ex_mem, fl_mem_wb}
    localparam logic [8:0] BOOTV = 9'b0_0000_1111;
    localparam logic [8:0] NORM  = 9'b1_1111_0000;
    localparam logic [8:0] MEMW  = 9'b0_0000_0001;
    localparam logic [8:0] MDUS  = 9'b0_0011_0010;
    localparam logic [8:0] REDIR = 9'b1_1111_1100;
    localparam logic [8:0] LU    = 9'b0_0111_0100;

    logic clk, rst_n;
    logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
    logic id_rs1_used, id_rs2_used, ex_valid, ex_mem_read, ex_redirect;
    logic ex_mdu_start, mdu_done, mem_req_valid, mem_ready;
    logic pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
    logic flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
`ifdef OSYRYS_STALL_PERF_EN
    logic [PERF_W-1:0] perf_loaduse_cnt, perf_memwait_cnt, perf_flush_cnt;
`endif
    logic [8:0] obs;

    int nvec = 0;
    int nerr = 0;

    // reference model: MDU outstanding, inside a mem-wait episode, completion seen during it
    logic m_boot, m_busy, m_memw, m_pend;
    logic n_busy, n_memw, n_pend;

    pipeline_ctrl #(.REG_AW(REG_AW), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_redirect(ex_redirect), .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
        .mem_req_valid(mem_req_valid), .mem_ready(mem_ready),
        .pc_en(pc_en), .en_if_id(en_if_id), .en_id_ex(en_id_ex),
        .en_ex_mem(en_ex_mem), .en_mem_wb(en_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .flush_ex_mem(flush_ex_mem), .flush_mem_wb(flush_mem_wb)
`ifdef OSYRYS_STALL_PERF_EN
        ,
        .perf_loaduse_cnt(perf_loaduse_cnt),
        .perf_memwait_cnt(perf_memwait_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    assign obs = {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                  flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2, rd;
        logic       rs1u, rs2u, valid, mread, redir, start, done, req, ready;
        logic [8:0] exp;
    } vec_t;

    function automatic vec_t mk(input string name, input logic [4:0] rs1, input logic rs1u,
                                input logic [4:0] rs2, input logic rs2u, input logic valid,
                                input logic mread, input logic [4:0] rd, input logic redir,
                                input logic start, input logic done, input logic req,
                                input logic ready, input logic [8:0] exp);
        vec_t v;
        v.name = name; v.rs1 = rs1; v.rs1u = rs1u; v.rs2 = rs2; v.rs2u = rs2u;
        v.valid = valid; v.mread = mread; v.rd = rd; v.redir = redir; v.start = start;
        v.done = done; v.req = req; v.ready = ready; v.exp = exp;
        return v;
    endfunction

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_rs1_used = 0; id_rs2_used = 0; ex_valid = 0; ex_mem_read = 0;
        ex_redirect = 0; ex_mdu_start = 0; mdu_done = 0; mem_req_valid = 0; mem_ready = 1;
    endtask

    // Bits the spec leaves open (enable of a register being flushed) are not compared
    task automatic check(input string name, input logic [8:0] exp);
        logic [8:0] m;
        m = 9'h1FF;
        if (exp == MDUS) m[5] = 1'b0;
        if (exp == LU)   m[6] = 1'b0;
        nvec++;
        if ((obs & m) !== (exp & m)) begin
            nerr++;
            $display("FAIL %s: got %b required %b (care mask %b)", name, obs, exp, m);
        end
    endtask

    task automatic check_cnt(input string name, input logic [PERF_W-1:0] got,
                             input logic [PERF_W-1:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Check this cycle's outputs at the falling edge, then advance past the rising edge
    task automatic cyc(input string name, input logic [8:0] exp);
        @(negedge clk);
        check(name, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic model(output logic [8:0] e);
        logic mw, lu, d;
        mw = mem_req_valid & !mem_ready;
        lu = ex_valid && ex_mem_read && ex_rd != 0 &&
             ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
        n_busy = m_busy; n_memw = m_memw; n_pend = m_pend;
        if (m_boot) begin
            e = BOOTV;
        end else if (mw) begin
            e = MEMW;
            if (m_memw) n_pend = m_pend | mdu_done;
            else begin
                n_memw = 1; n_pend = 0;
                n_busy = (m_busy | ex_mdu_start) & !mdu_done;
            end
        end else begin
            d = mdu_done | (m_memw & m_pend);
            n_memw = 0; n_pend = 0;
            if (m_busy) begin
                if (d) begin e = NORM; n_busy = 0; end
                else e = MDUS;
            end else if (ex_mdu_start && !mdu_done) begin
                e = MDUS; n_busy = 1;
            end else if (ex_redirect && ex_valid) e = REDIR;
            else if (lu) e = LU;
            else e = NORM;
        end
    endtask

    vec_t tbl[13];

    initial begin
        logic [8:0] e;
        tbl[0]  = mk("normal_idle",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM);
        tbl[1]  = mk("loaduse_rs1",     5, 1, 0, 0, 1, 1, 5, 0, 0, 0, 0, 1, LU);
        tbl[2]  = mk("after_loaduse",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM);
        tbl[3]  = mk("loaduse_rs2",     1, 1, 7, 1, 1, 1, 7, 0, 0, 0, 0, 1, LU);
        tbl[4]  = mk("rs2_match_unused",1, 1, 7, 0, 1, 1, 7, 0, 0, 0, 0, 1, NORM);
        tbl[5]  = mk("loaduse_rd0",     0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, NORM);
        tbl[6]  = mk("loaduse_invalid", 5, 1, 0, 0, 0, 1, 5, 0, 0, 0, 0, 1, NORM);
        tbl[7]  = mk("not_a_load",      5, 1, 0, 0, 1, 0, 5, 0, 0, 0, 0, 1, NORM);
        tbl[8]  = mk("rs1_mismatch",    4, 1, 0, 0, 1, 1, 5, 0, 0, 0, 0, 1, NORM);
        tbl[9]  = mk("redirect",        0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, REDIR);
        tbl[10] = mk("redirect_loaduse",5, 1, 0, 0, 1, 1, 5, 1, 0, 0, 0, 1, REDIR);
        tbl[11] = mk("redirect_invalid",0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, NORM);
        tbl[12] = mk("mdu_start_done",  0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1, NORM);

        idle();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_held", BOOTV);
        @(posedge clk);
        #1;
        rst_n = 1;
        cyc("boot_cycle", BOOTV);
        cyc("run_after_boot", NORM);

        foreach (tbl[i]) begin
            id_rs1 = tbl[i].rs1; id_rs1_used = tbl[i].rs1u;
            id_rs2 = tbl[i].rs2; id_rs2_used = tbl[i].rs2u;
            ex_valid = tbl[i].valid; ex_mem_read = tbl[i].mread; ex_rd = tbl[i].rd;
            ex_redirect = tbl[i].redir; ex_mdu_start = tbl[i].start; mdu_done = tbl[i].done;
            mem_req_valid = tbl[i].req; mem_ready = tbl[i].ready;
            cyc(tbl[i].name, tbl[i].exp);
        end
        idle();
`ifdef OSYRYS_STALL_PERF_EN
        check_cnt("perf_loaduse", perf_loaduse_cnt, 2);
        check_cnt("perf_flush", perf_flush_cnt, 2);
        check_cnt("perf_memwait", perf_memwait_cnt, 0);
`endif

        // 4-cycle MDU op: three stall cycles, then the done cycle
        ex_valid = 1; ex_mdu_start = 1;
        cyc("mdu_stall0", MDUS);
        cyc("mdu_stall1", MDUS);
        cyc("mdu_stall2", MDUS);
        mdu_done = 1;
        cyc("mdu_done", NORM);
        idle();
        cyc("mdu_after", NORM);

        // MDU busy, then a 3-cycle mem wait with the completion in its 2nd cycle
        ex_valid = 1; ex_mdu_start = 1;
        cyc("mdu_mw_stall", MDUS);
        mem_req_valid = 1; mem_ready = 0;
        cyc("mdu_mw0", MEMW);
        mdu_done = 1;
        cyc("mdu_mw1", MEMW);
        mdu_done = 0;
        cyc("mdu_mw2", MEMW);
        mem_ready = 1;
        cyc("mdu_mw_pending_done", NORM);
        idle();
        cyc("mdu_mw_run", NORM);
`ifdef OSYRYS_STALL_PERF_EN
        check_cnt("perf_memwait_3", perf_memwait_cnt, 3);
`endif

        // reset asserted while in MEM_WAIT
        mem_req_valid = 1; mem_ready = 0;
        cyc("rst_mw_enter", MEMW);
        #2;
        rst_n = 0;
        #1;
        check("rst_mid_memwait", BOOTV);
        idle();
        @(posedge clk);
        #1;
        rst_n = 1;
        cyc("rst_boot_cycle", BOOTV);
        cyc("rst_run", NORM);

        // randomized traffic against the reference model, starting from a fresh reset
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        m_boot = 1; m_busy = 0; m_memw = 0; m_pend = 0;
        for (int i = 0; i < 600; i++) begin
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            ex_rd  = 5'($urandom_range(0, 3));
            id_rs1_used   = ($urandom_range(0, 1) == 0);
            id_rs2_used   = ($urandom_range(0, 1) == 0);
            ex_valid      = ($urandom_range(0, 3) != 0);
            ex_mem_read   = ($urandom_range(0, 1) == 0);
            ex_redirect   = ($urandom_range(0, 7) == 0);
            ex_mdu_start  = ($urandom_range(0, 5) == 0);
            mdu_done      = ($urandom_range(0, 3) == 0);
            mem_req_valid = ($urandom_range(0, 2) == 0);
            mem_ready     = ($urandom_range(0, 3) != 0);
            model(e);
            cyc($sformatf("rand%0d", i), e);
            m_boot = 0; m_busy = n_busy; m_memw = n_memw; m_pend = n_pend;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
